// File: rtl/parity_arbiter_ctrl.sv
// parity_arbiter_ctrl: round-robin owner of one shared parity generator.
// Two byte-stream requesters, one burst at a time, parity+count response.
module parity_arbiter_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             odd_mode,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic [7:0]       par_data,
  input  logic             par_bit,
  output logic             resp_valid,
  output logic             resp_id,
  output logic             resp_parity,
  output logic [CNT_W-1:0] resp_count,
  input  logic             resp_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             grant;
  logic             prio;
  logic             acc;
  logic             odd_q;
  logic [CNT_W-1:0] cnt;

  logic             busy;
  logic             any_req;
  logic             win;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic             hs;
  logic             acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  assign busy    = (state == BUSY);
  assign any_req = req0_valid | req1_valid;

  // priority holder wins when valid, otherwise the other one
  assign win = prio ? req1_valid : ~req0_valid;

  assign req0_ready = busy & ~grant;
  assign req1_ready = busy & grant;

  assign sel_valid = grant ? req1_valid : req0_valid;
  assign sel_last  = grant ? req1_last : req0_last;
  assign sel_data  = grant ? req1_data : req0_data;

  assign par_data = busy ? sel_data : 8'h00;

  assign hs      = busy & sel_valid;
  assign acc_nxt = acc ^ par_bit;
  assign cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      prio        <= 1'b0;
      acc         <= 1'b0;
      odd_q       <= 1'b0;
      cnt         <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_parity <= 1'b0;
      resp_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant <= win;
            acc   <= 1'b0;
            cnt   <= '0;
            odd_q <= odd_mode;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (hs) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (sel_last) begin
              state       <= RESP;
              resp_valid  <= 1'b1;
              resp_id     <= grant;
              resp_parity <= acc_nxt ^ odd_q;
              resp_count  <= cnt_nxt;
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            state       <= IDLE;
            prio        <= ~grant;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_parity <= 1'b0;
            resp_count  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_arbiter_ctrl.sv
// tb_parity_arbiter_ctrl: random and directed bursts against a
// burst-level reference model of the round-robin parity service.
module tb_parity_arbiter_ctrl;

  localparam int CNT_W = 8;
  localparam int MAXC  = 255;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic id;
    logic par;
    int   cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             odd_mode = 1'b0;
  logic [1:0]       vld = '0;
  logic [1:0]       lst = '0;
  logic [7:0]       dat0 = '0;
  logic [7:0]       dat1 = '0;
  logic             rdy0;
  logic             rdy1;
  logic [7:0]       par_data;
  logic             par_bit;
  logic             resp_valid;
  logic             resp_id;
  logic             resp_parity;
  logic [CNT_W-1:0] resp_count;
  logic             resp_ready = 1'b0;

  logic [1:0]       active = '0;
  logic             prio_m = 1'b0;
  exp_t             expq[$];
  int               errors = 0;
  int               checks = 0;

  // behavioural stand-in for the shared parity generator
  assign par_bit = ^par_data;

  always #5 clk = ~clk;

  parity_arbiter_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .odd_mode   (odd_mode),
    .req0_valid (vld[0]),
    .req0_data  (dat0),
    .req0_last  (lst[0]),
    .req0_ready (rdy0),
    .req1_valid (vld[1]),
    .req1_data  (dat1),
    .req1_last  (lst[1]),
    .req1_ready (rdy1),
    .par_data   (par_data),
    .par_bit    (par_bit),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_parity(resp_parity),
    .resp_count (resp_count),
    .resp_ready (resp_ready)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input bq_t b,
                                 input logic odd);
    exp_t e;
    e.id  = id;
    e.par = odd;
    foreach (b[i]) e.par = e.par ^ (^b[i]);
    e.cnt = (b.size() > MAXC) ? MAXC : b.size();
    return e;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_rdy0"}, rdy0, 0);
    check({tag, "_rdy1"}, rdy1, 0);
    check({tag, "_par_data"}, par_data, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_id"}, resp_id, 0);
    check({tag, "_resp_parity"}, resp_parity, 0);
    check({tag, "_resp_count"}, resp_count, 0);
  endtask

  task automatic drive(input int r, input logic v,
                       input logic [7:0] d, input logic l);
    if (r == 0) begin
      vld[0] = v;
      dat0   = d;
      lst[0] = l;
    end else begin
      vld[1] = v;
      dat1   = d;
      lst[1] = l;
    end
  endtask

  // returns just after the accepting rising edge
  task automatic wait_accept(input int r, input logic [7:0] d,
                             output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      #1;
      if ((r == 0) ? rdy0 : rdy1) begin
        check("par_data", par_data, d);
        @(posedge clk);
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic send(input int r, input bq_t b,
                      input int gmin, input int gmax);
    bit ok;
    logic l;
    active[r] = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      l = (i == b.size() - 1);
      if (i > 0) repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      drive(r, 1'b1, b[i], l);
      wait_accept(r, b[i], ok);
      @(negedge clk);
      drive(r, 1'b0, 8'h00, 1'b0);
      if (!ok) break;
      if (l) begin
        check("resp_next_cycle", resp_valid, 1);
        check("resp_id_early", resp_id, r);
      end
    end
    active[r] = 1'b0;
  endtask

  task automatic collect(input int n, input int hmin, input int hmax);
    exp_t e;
    int   t;
    int   hold;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (resp_valid !== 1'b1 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (resp_valid !== 1'b1) begin
        check("resp_timeout", 0, 1);
        return;
      end
      if (expq.size() == 0) begin
        check("resp_unexpected", 1, 0);
        return;
      end
      e = expq.pop_front();
      check("resp_id", resp_id, e.id);
      check("resp_parity", resp_parity, e.par);
      check("resp_count", resp_count, e.cnt);
      hold = $urandom_range(hmax, hmin);
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", resp_valid, 1);
        check("hold_id", resp_id, e.id);
        check("hold_parity", resp_parity, e.par);
        check("hold_count", resp_count, e.cnt);
        check("hold_no_grant", {rdy1, rdy0}, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("resp_drop", resp_valid, 0);
    end
  endtask

  // changes odd_mode once the burst is under way
  task automatic flipper(input logic odd);
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (rdy0 | rdy1) begin
        odd_mode = ~odd;
        return;
      end
    end
  endtask

  task automatic run(input bq_t b0, input bq_t b1, input logic odd,
                     input int gmin, input int gmax,
                     input int hmin, input int hmax, input bit flip);
    int   n;
    logic f;
    n = 0;
    if (b0.size() > 0 && b1.size() > 0) begin
      f = prio_m;
      expq.push_back(model(f, f ? b1 : b0, odd));
      expq.push_back(model(~f, f ? b0 : b1, odd));
      prio_m = f;
      n = 2;
    end else if (b0.size() > 0) begin
      expq.push_back(model(1'b0, b0, odd));
      prio_m = 1'b1;
      n = 1;
    end else if (b1.size() > 0) begin
      expq.push_back(model(1'b1, b1, odd));
      prio_m = 1'b0;
      n = 1;
    end
    odd_mode = odd;
    fork
      if (b0.size() > 0) send(0, b0, gmin, gmax);
      if (b1.size() > 0) send(1, b1, gmin, gmax);
      collect(n, hmin, hmax);
      if (flip) flipper(odd);
    join
    check("exp_left", expq.size(), 0);
    expq.delete();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prio_m = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && (rdy0 | rdy1)) begin
      check("ready_onehot", rdy0 & rdy1, 0);
      check("ready_owner", rdy0 ? active[0] : active[1], 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t  a;
    bq_t  b;
    bq_t  none;
    bit   ok;
    int   sel;
    logic odd;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    a = '{8'hAA, 8'hE0, 8'h00};
    run(a, none, 1'b0, 0, 0, 0, 0, 1'b0);

    b = '{8'hFF};
    run(none, b, 1'b1, 0, 0, 0, 0, 1'b1);

    do_reset();
    a = '{8'h01, 8'h02};
    b = '{8'h01, 8'h02};
    run(a, b, 1'b0, 0, 0, 0, 0, 1'b0);
    run(a, b, 1'b0, 0, 0, 0, 0, 1'b0);

    a = '{8'h5A, 8'h3C};
    b = '{8'h77};
    run(a, b, 1'b0, 0, 0, 5, 5, 1'b0);

    a = '{8'h10, 8'h20, 8'h31, 8'h40};
    run(a, none, 1'b1, 3, 3, 0, 0, 1'b1);

    a.delete();
    repeat (300) a.push_back(8'h01);
    run(a, none, 1'b0, 0, 0, 0, 0, 1'b0);

    active[0] = 1'b1;
    drive(0, 1'b1, 8'h11, 1'b0);
    wait_accept(0, 8'h11, ok);
    @(negedge clk);
    drive(0, 1'b1, 8'h22, 1'b0);
    wait_accept(0, 8'h22, ok);
    @(negedge clk);
    drive(0, 1'b1, 8'h33, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero("mid_reset");
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    active[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    prio_m = 1'b0;
    repeat (3) @(negedge clk);
    check("no_resp_after_reset", resp_valid, 0);
    a = '{8'h07};
    run(a, none, 1'b0, 0, 0, 0, 0, 1'b0);

    for (int s = 0; s < 40; s++) begin
      a.delete();
      b.delete();
      sel = $urandom_range(3, 1);
      if (sel[0]) repeat ($urandom_range(12, 1)) a.push_back(8'($urandom));
      if (sel[1]) repeat ($urandom_range(12, 1)) b.push_back(8'($urandom));
      odd = 1'($urandom);
      run(a, b, odd, 0, $urandom_range(3, 0), 0, $urandom_range(3, 0),
          sel != 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
